// File: rtl/fdc_mb8877.sv
// MB8877-compatible floppy controller: CPU register file, Type I/II command FSM, 256-byte sector buffer.
// Optional macro FDC_WRITE_EN builds Write Sector; without it Write Sector ends at once with write-protect.
module fdc_mb8877 #(
  parameter int BYTE_CYCLES = 256,
  parameter int STEP_CYCLES = 2048,
  parameter int TRACKS      = 40,
  parameter int SECTORS     = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs_n,
  input  logic [2:0]  rs,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  input  logic        we_n,
  input  logic        re_n,
  input  logic        mr_n,
  output logic        drq_n,
  output logic        intrq_n,
  input  logic        img_mounted,
  input  logic        img_wp,
  output logic [15:0] img_lba,
  output logic        img_rd,
  output logic        img_wr,
  input  logic        img_ack,
  input  logic [7:0]  img_addr,
  input  logic [7:0]  img_dout,
  input  logic        img_wren,
  output logic [7:0]  img_din
);

  typedef enum logic [2:0] {
    S_IDLE, S_STEP, S_CHECK, S_LOAD, S_XFER_RD, S_XFER_WR, S_FLUSH, S_DONE
  } state_t;

  state_t      state_q;
  logic [2:0]  we_s_q, re_s_q;
  logic [1:0]  mr_s_q;
  logic [7:0]  track_q, sector_q, data_q, head_q, img_din_q, status;
  logic [3:0]  cmd_q;
  logic [1:0]  drive_q;
  logic        side_q, motor_q, dir_q, type1_q;
  logic        busy_q, nr_q, wp_q, rnf_q, lost_q, drq_q, intrq_q, img_rd_q;
  logic [8:0]  idx_q, idx_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  mem_q [256];
  logic [13:0] lba;
  logic        rst, wr_evt, rd_evt, data_rd, step_end, slot_end;

  assign rst      = reset | ~mr_s_q[1];
  // [1] is the synchronized strobe, [2] its previous value
  assign wr_evt   = we_s_q[2] & ~we_s_q[1] & ~cs_n;
  assign rd_evt   = re_s_q[2] & ~re_s_q[1] & ~cs_n;
  assign data_rd  = rd_evt & (rs == 3'd3);
  assign cnt_d    = cnt_q + 16'd1;
  assign idx_d    = idx_q + 9'd1;
  assign step_end = (cnt_q == 16'(STEP_CYCLES - 1));
  assign slot_end = (cnt_q == 16'(BYTE_CYCLES - 1));
  assign lba      = 14'({track_q, side_q}) * 14'(SECTORS) + 14'(sector_q) - 14'd1;
  assign img_lba  = {drive_q, lba};
  assign img_rd   = img_rd_q;
  assign img_din  = img_din_q;
  assign drq_n    = ~drq_q;
  assign intrq_n  = ~intrq_q;
  assign status   = type1_q ? {nr_q, wp_q, motor_q, 2'b00, head_q == 8'd0, 1'b0, busy_q}
                            : {nr_q, wp_q, 1'b0, rnf_q, 1'b0, lost_q, drq_q, busy_q};

`ifdef FDC_WRITE_EN
  logic       img_wr_q, data_wr, cpu_we;
  logic [7:0] cpu_dat;
  assign data_wr = wr_evt & (rs == 3'd3);
  // an expired slot with DRQ still pending stores 0x00
  assign cpu_we  = (state_q == S_XFER_WR) & (data_wr | (slot_end & drq_q));
  assign cpu_dat = data_wr ? din : 8'h00;
  assign img_wr  = img_wr_q;
`else
  assign img_wr  = 1'b0;
`endif

  function automatic logic [7:0] head_move(input logic [7:0] h, input logic inward);
    if (inward) return (h == 8'(TRACKS - 1)) ? h : h + 8'd1;
    return (h == 8'd0) ? h : h - 8'd1;
  endfunction

  always_comb begin
    dout = 8'h00;
    case (rs)
      3'd0:    dout = status;
      3'd1:    dout = track_q;
      3'd2:    dout = sector_q;
      3'd3:    dout = data_q;
      3'd4:    dout = {7'h7F, side_q};
      3'd5:    dout = {motor_q, 5'h1F, drive_q};
      default: dout = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (img_wren) mem_q[img_addr] <= img_dout;
`ifdef FDC_WRITE_EN
    if (cpu_we) mem_q[idx_q[7:0]] <= cpu_dat;
`endif
    img_din_q <= mem_q[img_addr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      we_s_q <= 3'b111;
      re_s_q <= 3'b111;
      mr_s_q <= 2'b11;
    end else begin
      we_s_q <= {we_s_q[1:0], we_n};
      re_s_q <= {re_s_q[1:0], re_n};
      mr_s_q <= {mr_s_q[0], mr_n};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      track_q  <= 8'd0;
      sector_q <= 8'd1;
      data_q   <= 8'd0;
      head_q   <= 8'd0;
      cmd_q    <= 4'd0;
      drive_q  <= 2'd0;
      side_q   <= 1'b0;
      motor_q  <= 1'b0;
      dir_q    <= 1'b0;
      type1_q  <= 1'b0;
      busy_q   <= 1'b0;
      nr_q     <= 1'b0;
      wp_q     <= 1'b0;
      rnf_q    <= 1'b0;
      lost_q   <= 1'b0;
      drq_q    <= 1'b0;
      intrq_q  <= 1'b0;
      img_rd_q <= 1'b0;
      idx_q    <= 9'd0;
      cnt_q    <= 16'd0;
`ifdef FDC_WRITE_EN
      img_wr_q <= 1'b0;
`endif
    end else begin
      if (wr_evt) begin
        case (rs)
          3'd1: track_q  <= din;
          3'd2: sector_q <= din;
          3'd3: begin data_q <= din; drq_q <= 1'b0; end
          3'd4: side_q   <= din[0];
          3'd5: begin drive_q <= din[1:0]; motor_q <= din[7]; end
          default: ;
        endcase
      end
      if (rd_evt && rs == 3'd0) intrq_q <= 1'b0;
      if (data_rd) drq_q <= 1'b0;

      case (state_q)
        S_STEP: begin
          cnt_q <= step_end ? 16'd0 : cnt_d;
          if (cmd_q == 4'h0) begin
            if (head_q == 8'd0) begin
              track_q <= 8'd0;
              state_q <= S_DONE;
            end else if (step_end) begin
              dir_q  <= 1'b0;
              head_q <= head_move(head_q, 1'b0);
            end
          end else if (cmd_q == 4'h1) begin
            if (track_q == data_q) state_q <= S_DONE;
            else if (step_end) begin
              dir_q   <= (data_q > track_q);
              head_q  <= head_move(head_q, data_q > track_q);
              track_q <= (data_q > track_q) ? track_q + 8'd1 : track_q - 8'd1;
            end
          end else if (step_end) begin
            head_q <= head_move(head_q, dir_q);
            if (cmd_q[0]) track_q <= dir_q ? track_q + 8'd1 : (track_q == 8'd0 ? 8'd0 : track_q - 8'd1);
            state_q <= S_DONE;
          end
        end
        S_CHECK: begin
          cnt_q <= 16'd0;
          idx_q <= 9'd0;
          if (!img_mounted) begin
            nr_q <= 1'b1; state_q <= S_DONE;
          end else if (sector_q == 8'd0 || sector_q > 8'(SECTORS)) begin
            rnf_q <= 1'b1; state_q <= S_DONE;
          end else if (!cmd_q[1]) begin
            img_rd_q <= 1'b1; state_q <= S_LOAD;
`ifdef FDC_WRITE_EN
          end else if (img_wp) begin
            wp_q <= 1'b1; state_q <= S_DONE;
          end else begin
            drq_q <= 1'b1; state_q <= S_XFER_WR;
          end
`else
          end else begin
            wp_q <= 1'b1; state_q <= S_DONE;
          end
`endif
        end
        S_LOAD: begin
          if (img_rd_q) begin
            if (img_ack) img_rd_q <= 1'b0;
          end else if (!img_ack) begin
            cnt_q <= 16'd0; idx_q <= 9'd0; state_q <= S_XFER_RD;
          end
        end
        S_XFER_RD: begin
          cnt_q <= slot_end ? 16'd0 : cnt_d;
          if (slot_end) begin
            if (drq_q && !data_rd) lost_q <= 1'b1;
            if (idx_q[8]) begin
              drq_q <= 1'b0; state_q <= S_DONE;
            end else begin
              data_q <= mem_q[idx_q[7:0]]; drq_q <= 1'b1; idx_q <= idx_d;
            end
          end
        end
`ifdef FDC_WRITE_EN
        S_XFER_WR: begin
          cnt_q <= slot_end ? 16'd0 : cnt_d;
          if (slot_end) begin
            if (drq_q && !data_wr) lost_q <= 1'b1;
            if (idx_q[7:0] == 8'hFF) begin
              drq_q <= 1'b0; img_wr_q <= 1'b1; state_q <= S_FLUSH;
            end else begin
              drq_q <= 1'b1; idx_q <= idx_d;
            end
          end
        end
        S_FLUSH: begin
          if (img_wr_q) begin
            if (img_ack) img_wr_q <= 1'b0;
          end else if (!img_ack) state_q <= S_DONE;
        end
`endif
        S_DONE: begin
          busy_q <= 1'b0; intrq_q <= 1'b1; state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase

      // command writes come last so Force Interrupt overrides any FSM update
      if (wr_evt && rs == 3'd0) begin
        if (din[7:4] == 4'hD) begin
          state_q  <= S_IDLE;
          busy_q   <= 1'b0;
          drq_q    <= 1'b0;
          img_rd_q <= 1'b0;
          {nr_q, wp_q, rnf_q, lost_q} <= 4'b0;
          intrq_q  <= |din[3:0];
`ifdef FDC_WRITE_EN
          img_wr_q <= 1'b0;
`endif
        end else if (state_q == S_IDLE) begin
          intrq_q <= 1'b0;
          busy_q  <= 1'b1;
          {nr_q, wp_q, rnf_q, lost_q} <= 4'b0;
          cmd_q   <= din[7:4];
          type1_q <= ~din[7];
          cnt_q   <= 16'd0;
          if (!din[7]) begin
            nr_q    <= ~img_mounted;
            wp_q    <= img_wp;
            if (din[6]) dir_q <= ~din[5];
            state_q <= S_STEP;
          end else if (din[7:4] == 4'h8) begin
            state_q <= S_CHECK;
          end else if (din[7:4] == 4'hA) begin
`ifdef FDC_WRITE_EN
            state_q <= S_CHECK;
`else
            wp_q    <= 1'b1;
            state_q <= S_DONE;
`endif
          end else begin
            state_q <= S_DONE;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_fdc_mb8877.sv
// Directed bench for fdc_mb8877: seek, sector read/write through an image responder, errors, abort, master reset.
module tb_fdc_mb8877;
  localparam int BC = 32;
  localparam int SC = 64;

  logic        clk = 1'b0, reset = 1'b1, cs_n = 1'b1, we_n = 1'b1, re_n = 1'b1, mr_n = 1'b1;
  logic [2:0]  rs = 3'd0;
  logic [7:0]  din = 8'd0;
  logic        img_mounted = 1'b1, img_wp = 1'b0, img_ack = 1'b0, img_wren = 1'b0;
  logic [7:0]  img_addr = 8'd0, img_dout = 8'd0;
  logic [7:0]  dout, img_din;
  logic        drq_n, intrq_n, img_rd, img_wr;
  logic [15:0] img_lba;
  logic        stall = 1'b0;
  logic [7:0]  got [256];
  logic [7:0]  sb_q [$];
  int          errors = 0, checks = 0;

  fdc_mb8877 #(.BYTE_CYCLES(BC), .STEP_CYCLES(SC), .TRACKS(40), .SECTORS(16)) dut (
    .clk(clk), .reset(reset), .cs_n(cs_n), .rs(rs), .din(din), .dout(dout),
    .we_n(we_n), .re_n(re_n), .mr_n(mr_n), .drq_n(drq_n), .intrq_n(intrq_n),
    .img_mounted(img_mounted), .img_wp(img_wp), .img_lba(img_lba),
    .img_rd(img_rd), .img_wr(img_wr), .img_ack(img_ack), .img_addr(img_addr),
    .img_dout(img_dout), .img_wren(img_wren), .img_din(img_din)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic peek(input logic [2:0] r, output logic [7:0] v);
    rs = r;
    #1 v = dout;
  endtask

  task automatic cpu_wr(input logic [2:0] r, input logic [7:0] d);
    @(negedge clk);
    cs_n = 1'b0; rs = r; din = d; we_n = 1'b0;
    repeat (5) @(posedge clk);
    #1 we_n = 1'b1; cs_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic cpu_rd(input logic [2:0] r, output logic [7:0] v);
    @(negedge clk);
    cs_n = 1'b0; rs = r; re_n = 1'b0;
    #1 v = dout;
    repeat (5) @(posedge clk);
    #1 re_n = 1'b1; cs_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic wait_drq(input string tag);
    int n = 0;
    while (drq_n !== 1'b0 && n < 600) begin @(posedge clk); #1; n++; end
    chk(tag, 16'(drq_n), 16'd0);
  endtask

  task automatic wait_intrq(input int lim, output int cyc, output logic saw);
    int n = 0;
    saw = 1'b0;
    while (intrq_n !== 1'b0 && n < lim) begin
      @(posedge clk); #1; n++;
      if (drq_n === 1'b0) saw = 1'b1;
    end
    cyc = n;
    chk("intrq_wait", 16'(intrq_n), 16'd0);
  endtask

  // sector read with the CPU optionally ignoring one DRQ slot
  task automatic do_read(input int skip, input logic [7:0] exp_status);
    logic [7:0] v, e;
    int n = 0, cyc;
    logic saw;
    for (int k = 0; k < 256; k++) sb_q.push_back(8'(k) ^ 8'hA5);
    cpu_wr(3'd0, 8'h80);
    while (img_rd !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    chk("rd_req", 16'(img_rd), 16'd1);
    chk("rd_lba", img_lba, 16'h0052);
    for (int k = 0; k < 256; k++) begin
      e = sb_q.pop_front();
      wait_drq("rd_drq");
      if (k == skip) begin
        repeat (BC) @(posedge clk);
        #1;
        continue;
      end
      cpu_rd(3'd3, v);
      chk("rd_byte", 16'(v), 16'(e));
    end
    wait_intrq(200, cyc, saw);
    cpu_rd(3'd0, v);
    chk("rd_status", 16'(v), 16'(exp_status));
    chk("rd_intrq_clr", 16'(intrq_n), 16'd1);
  endtask

  // image side: fills the buffer with i^0xA5 on reads, captures img_din on flushes
  initial begin
    forever begin
      @(posedge clk); #1;
      if (img_rd && !stall) begin
        repeat (3) @(posedge clk);
        #1 img_ack = 1'b1;
        for (int i = 0; i < 256; i++) begin
          img_addr = 8'(i); img_dout = 8'(i) ^ 8'hA5; img_wren = 1'b1;
          @(posedge clk); #1;
        end
        img_wren = 1'b0; img_ack = 1'b0;
      end else if (img_wr) begin
        img_ack = 1'b1;
        for (int i = 0; i < 256; i++) begin
          img_addr = 8'(i);
          @(posedge clk); #1;
          got[i] = img_din;
        end
        img_ack = 1'b0;
      end
    end
  end

  initial begin
    logic [7:0] v;
    int cyc, n;
    logic saw;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    peek(3'd0, v); chk("rst_status", 16'(v), 16'h00);
    peek(3'd1, v); chk("rst_track", 16'(v), 16'd0);
    peek(3'd2, v); chk("rst_sector", 16'(v), 16'd1);
    chk("rst_drq", 16'(drq_n), 16'd1);
    chk("rst_intrq", 16'(intrq_n), 16'd1);
    chk("rst_lba", img_lba, 16'h0000);
    chk("rst_img_rd", 16'(img_rd), 16'd0);

    cpu_wr(3'd5, 8'h80);
    peek(3'd5, v); chk("drive_rd", 16'(v), 16'hFC);
    cpu_wr(3'd3, 8'd5);
    cpu_wr(3'd0, 8'h18);
    peek(3'd0, v); chk("seek_busy", 16'(v), 16'h25);
    wait_intrq(1000, cyc, saw);
    chk("seek_time", 16'(cyc >= 5*SC - 10 && cyc <= 5*SC + 10), 16'd1);
    peek(3'd1, v); chk("seek_track", 16'(v), 16'd5);
    cpu_rd(3'd0, v); chk("seek_status", 16'(v), 16'h20);
    chk("seek_intrq_clr", 16'(intrq_n), 16'd1);

    cpu_wr(3'd1, 8'd2);
    cpu_wr(3'd4, 8'd1);
    cpu_wr(3'd2, 8'd3);
    peek(3'd4, v); chk("side_rd", 16'(v), 16'hFF);
    do_read(-1, 8'h00);
    do_read(10, 8'h04);

    cpu_wr(3'd2, 8'd17);
    cpu_wr(3'd0, 8'h80);
    wait_intrq(100, cyc, saw);
    cpu_rd(3'd0, v); chk("rnf_status", 16'(v), 16'h10);
    cpu_wr(3'd2, 8'd3);

    cpu_wr(3'd0, 8'hF0);
    wait_intrq(100, cyc, saw);
    cpu_rd(3'd0, v); chk("other_status", 16'(v), 16'h00);

    stall = 1'b1;
    cpu_wr(3'd0, 8'h80);
    n = 0;
    while (img_rd !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    chk("fi_req", 16'(img_rd), 16'd1);
    @(negedge clk);
    cs_n = 1'b0; rs = 3'd0; din = 8'hD8; we_n = 1'b0;
    n = 0;
    while (!(img_rd === 1'b0 && intrq_n === 1'b0 && dout[0] === 1'b0) && n < 6) begin
      @(posedge clk); #1; n++;
    end
    chk("fi_img_rd", 16'(img_rd), 16'd0);
    chk("fi_intrq", 16'(intrq_n), 16'd0);
    chk("fi_busy", 16'(dout[0]), 16'd0);
    chk("fi_latency", 16'(n <= 4), 16'd1);
    repeat (3) @(posedge clk);
    #1 we_n = 1'b1; cs_n = 1'b1; stall = 1'b0;
    repeat (3) @(posedge clk);

`ifdef FDC_WRITE_EN
    cpu_wr(3'd0, 8'hA0);
    for (int k = 0; k < 256; k++) begin
      wait_drq("wr_drq");
      cpu_wr(3'd3, 8'(k));
      sb_q.push_back(8'(k));
    end
    wait_intrq(2000, cyc, saw);
    for (int i = 0; i < 256; i++) begin
      v = sb_q.pop_front();
      chk("wr_img_din", 16'(got[i]), 16'(v));
    end
    cpu_rd(3'd0, v); chk("wr_status", 16'(v), 16'h00);
    img_wp = 1'b1;
`endif
    cpu_wr(3'd0, 8'hA0);
    wait_intrq(200, cyc, saw);
    chk("wp_no_drq", 16'(saw), 16'd0);
    cpu_rd(3'd0, v); chk("wp_status", 16'(v), 16'h40);
    img_wp = 1'b0;

    cpu_wr(3'd3, 8'd10);
    cpu_wr(3'd0, 8'h10);
    repeat (100) @(posedge clk);
    #1 mr_n = 1'b0;
    repeat (4) @(posedge clk);
    #1 mr_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    peek(3'd0, v); chk("mr_status", 16'(v), 16'h00);
    peek(3'd1, v); chk("mr_track", 16'(v), 16'd0);
    peek(3'd2, v); chk("mr_sector", 16'(v), 16'd1);
    peek(3'd5, v); chk("mr_drive", 16'(v), 16'h7C);
    chk("mr_intrq", 16'(intrq_n), 16'd1);
    chk("mr_drq", 16'(drq_n), 16'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fdc_mb8877.md
# fdc_mb8877

MB8877-compatible floppy disk controller core: the device that answers the FM-7 disk glue's chip-select, register-select and strobe signals. It sits on the far side of that glue. It provides the command/status, track, sector and data registers, plus the side and drive latches. Its DRQ/INTRQ lines feed the glue's $FD1F status and IRQ logic. Sector data moves between a 256-byte internal buffer and a block-addressed disk-image port.

## Interface
- BYTE_CYCLES, 256: clk cycles between successive DRQ byte slots during a transfer
- STEP_CYCLES, 2048: clk cycles per head step
- TRACKS, 40: tracks per side; the head position saturates at TRACKS-1
- SECTORS, 16: sectors per track; sector numbers run 1..SECTORS
- Clock and reset: one clock; reset is synchronous and active-high.
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- cs_n  in  1  chip select, low for $FD18-$FD1D
- rs  in  3  register select; 0 cmd/status, 1 track, 2 sector, 3 data, 4 side, 5 drive
- din  in  8  CPU write data
- dout  out  8  register read data
- we_n  in  1  write strobe, active low, asynchronous to clk
- re_n  in  1  read strobe, active low, asynchronous to clk
- mr_n  in  1  master reset, active low; same effect as reset
- drq_n  out  1  data request, active low
- intrq_n  out  1  interrupt request, active low
- img_mounted  in  1  image present (drive ready)
- img_wp  in  1  image is write-protected
- img_lba  out  16  block address: ((track*2+side)*SECTORS + sector-1); drive number in bits 15:14
- img_rd  out  1  block read request
- img_wr  out  1  block write request
- img_ack  in  1  high while the image side services a request
- img_addr  in  8  buffer byte address
- img_dout  in  8  image to buffer data
- img_wren  in  1  write img_dout into buffer[img_addr]
- img_din  out  8  buffer[img_addr], registered with 1-cycle latency

## Operation
- Strobe handling:
  - we_n, re_n and mr_n pass through two synchronizer flops.
  - A falling edge of we_n or re_n with cs_n low is one access; rs and din are sampled on that edge.
- Register writes:
  - cmd: clears INTRQ and starts a command. Writes while busy are ignored, except Force Interrupt.
  - track, sector: loaded directly.
  - data: loads the data register.
  - side: bit0 is the side.
  - drive: bits1:0 select the drive, bit7 is the motor bit.
- Register reads:
  - status: clears INTRQ.
  - data: returns the data register and clears DRQ.
  - side and drive: return {7'h7F,side} and {motor,5'h1F,drive}.
- Commands:
  - Restore (0x0X): steps out until track 0, then sets track=0.
  - Seek (0x1X): steps toward the data register value, then sets track=data.
  - Step (0x2X/3X), Step-in (0x4X/5X), Step-out (0x6X/7X): one step in the current, inward or outward direction. Bit4 set updates the track register.
  - Read Sector (0x8X): transfers one sector from the image to the CPU.
  - Write Sector (0xAX): transfers one sector from the CPU to the image.
  - Force Interrupt (0xDX): aborts any command. INTRQ is asserted if bits3:0 are nonzero.
  - Any other command ends immediately with INTRQ and no status error.
- State machine:
  - IDLE -> STEP (Type I) or CHECK (Type II).
  - STEP: one step per STEP_CYCLES, then DONE.
  - CHECK: not mounted -> DONE with status bit7 set. Sector 0 or sector > SECTORS -> DONE with RNF (bit4). Otherwise LOAD (read) or XFER_WR (write).
  - LOAD: assert img_rd until img_ack rises, then wait for img_ack to fall. Go to XFER_RD.
  - XFER_RD: every BYTE_CYCLES, move buffer[idx] to data and assert DRQ. Lost data applies (below). After byte 255 -> DONE.
  - XFER_WR: assert DRQ for each slot. On a data write, store to buffer[idx] and clear DRQ. After 256 slots -> FLUSH.
  - FLUSH: img_wr handshake, same as LOAD, then DONE.
  - DONE: clear busy, assert INTRQ, return to IDLE.
- Lost data: when a slot expires with DRQ still set, set status bit2. For reads the new byte overwrites data; for writes the slot is stored as 0x00. The transfer continues.
- Status, Type I: bit7 not ready, bit6 wp, bit5 head loaded (=motor), bit2 track0, bit0 busy.
- Status, Type II: bit7 not ready, bit6 wp, bit4 RNF, bit2 lost data, bit1 DRQ, bit0 busy.
- Every new command clears the error bits.

## Timing
- Reset values:
  - dout=0x00, drq_n=1, intrq_n=1, img_rd=0, img_wr=0, img_lba=0.
  - status=0x00, track=0, sector=1, data=0, side=0, drive=0, state IDLE.
- Latencies:
  - A strobe takes effect 3 clk after its falling edge.
  - busy is set 1 clk after the command write is detected.
  - dout is a combinational mux of the registers selected by rs.
- First byte: the first read DRQ comes BYTE_CYCLES after LOAD completes. The first write DRQ comes 1 clk after CHECK.
- Handshakes: img_rd and img_wr drop on the img_ack rising edge. If img_ack never rises, the block waits indefinitely.
- Boundaries:
  - Simultaneous data access and slot expiry: the access wins and no lost data is flagged.
  - Force Interrupt during LOAD or FLUSH: img_rd/img_wr drop at once.
  - reset or mr_n mid-command returns everything to reset values in 1 clk.
  - img_mounted falling during a transfer: the transfer completes normally.

## Configuration
- FDC_WRITE_EN defined: Write Sector behaves as described.
- FDC_WRITE_EN undefined: Write Sector goes straight to DONE with status 0x40 (WP). img_wr is tied to 0 and no XFER_WR/FLUSH logic is built.
- With FDC_WRITE_EN defined, img_wp=1 also ends Write Sector with 0x40 and no DRQ.

## Test plan
- Reset -> dout(rs=0)=0x00, drq_n=1, intrq_n=1, track=0, sector=1.
- data=5, cmd 0x18 (Seek with update) -> busy for 5*STEP_CYCLES, then track=5, intrq_n=0; a status read returns 0x20 with motor set and clears INTRQ.
- track=2, side=1, sector=3, cmd 0x80 -> img_lba=0x0052. Image supplies buffer i=i^0xA5. 256 DRQs; reads return 0xA5,0xA4,…; final INTRQ with status 0x00.
- Same read with the CPU skipping byte 10 -> status bit2 set; byte 11 value delivered.
- FDC_WRITE_EN defined, cmd 0xA0, CPU writes 0..255 -> img_wr handshake; img_din matches byte for byte. With img_wp=1 -> status 0x40, no DRQ.
- cmd 0x80 with sector=17 -> status 0x10, intrq_n=0. cmd 0xD8 mid-read -> img_rd=0, busy=0, intrq_n=0 within 4 clk.
